// File: rtl/button_debouncer.sv
// Push-button front end: 2-FF synchronizer, 4-state debounce FSM, and registered
// press/release/long-press strobes with a debounced level and a wrapping press counter.
module button_debouncer #(
  parameter int DEBOUNCE_W   = 20,
  parameter int DEBOUNCE_MAX = 500000,
  parameter int LONG_W       = 26,
  parameter int LONG_MAX     = 50000000,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       btn_in,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_pulse,
  output logic       was_long,
  output logic [7:0] press_count
);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_CHECK,
    PRESSED,
    RELEASE_CHECK
  } state_t;

  localparam logic                  PIN_IDLE  = (ACTIVE_LOW != 0);
  localparam logic [DEBOUNCE_W-1:0] DB_LAST   = DEBOUNCE_W'(DEBOUNCE_MAX - 1);
  localparam logic [LONG_W-1:0]     HOLD_LAST = LONG_W'(LONG_MAX - 1);
  localparam logic [LONG_W-1:0]     HOLD_MAX  = LONG_W'(LONG_MAX);

  logic                  s1, s2, pressed;
  state_t                state, state_d;
  logic [DEBOUNCE_W-1:0] db_cnt, db_cnt_d;
  logic [LONG_W-1:0]     hold_cnt, hold_cnt_d;
  logic                  level_d, press_d, release_d, long_d, was_long_d;
  logic [7:0]            count_d;

  // Synchronizer resets to the idle pin level so reset never looks like a press.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      s1 <= PIN_IDLE;
      s2 <= PIN_IDLE;
    end else begin
      // NOTE: non-blocking assignments make s2 take s1's pre-edge value, giving a true two-stage chain.
      s1 <= btn_in;
      s2 <= s1;
    end
  end

  assign pressed = (ACTIVE_LOW != 0) ? ~s2 : s2;

  always_comb begin
    // NOTE: every signal gets a default before the case, so no path can infer a latch.
    state_d    = state;
    db_cnt_d   = db_cnt;
    hold_cnt_d = hold_cnt;
    level_d    = btn_level;
    press_d    = 1'b0;
    release_d  = 1'b0;
    long_d     = 1'b0;
    was_long_d = 1'b0;
    count_d    = press_count;

    // Hold time accrues through release bounce; saturation makes the long strobe single-shot.
    if ((state == PRESSED || state == RELEASE_CHECK) && hold_cnt != HOLD_MAX) begin
      hold_cnt_d = hold_cnt + LONG_W'(1);
      long_d     = (hold_cnt == HOLD_LAST);
    end

    case (state)
      RELEASED: begin
        if (pressed) begin
          state_d  = PRESS_CHECK;
          db_cnt_d = '0;
        end
      end
      PRESS_CHECK: begin
        if (!pressed) begin
          state_d = RELEASED;
        end else if (db_cnt == DB_LAST) begin
          state_d    = PRESSED;
          level_d    = 1'b1;
          press_d    = 1'b1;
          count_d    = press_count + 8'd1;
          hold_cnt_d = '0;
        end else begin
          db_cnt_d = db_cnt + DEBOUNCE_W'(1);
        end
      end
      PRESSED: begin
        if (!pressed) begin
          state_d  = RELEASE_CHECK;
          db_cnt_d = '0;
        end
      end
      RELEASE_CHECK: begin
        if (pressed) begin
          state_d = PRESSED;
        end else if (db_cnt == DB_LAST) begin
          // Release wins over a coincident long threshold.
          state_d    = RELEASED;
          level_d    = 1'b0;
          release_d  = 1'b1;
          long_d     = 1'b0;
          was_long_d = (hold_cnt == HOLD_MAX);
        end else begin
          db_cnt_d = db_cnt + DEBOUNCE_W'(1);
        end
      end
      default: state_d = RELEASED;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state         <= RELEASED;
      db_cnt        <= '0;
      hold_cnt      <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      was_long      <= 1'b0;
      press_count   <= 8'd0;
    end else begin
      state         <= state_d;
      db_cnt        <= db_cnt_d;
      hold_cnt      <= hold_cnt_d;
      btn_level     <= level_d;
      press_pulse   <= press_d;
      release_pulse <= release_d;
      long_pulse    <= long_d;
      was_long      <= was_long_d;
      press_count   <= count_d;
    end
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer: expected strobes are queued when the pin is
// driven and matched (kind, cycle, level, was_long, count) when the DUT emits them.
module tb_button_debouncer;

  localparam int DB   = 4;
  localparam int LONG = 16;

  typedef enum logic [1:0] {EV_NONE, EV_PRESS, EV_RELEASE, EV_LONG} ev_kind_t;

  typedef struct {
    ev_kind_t   kind;
    int         cyc;
    logic       level;
    logic       was_long;
    logic [7:0] count;
  } ev_t;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       btn_in;
  logic       btn_level, press_pulse, release_pulse, long_pulse, was_long;
  logic [7:0] press_count;

  ev_t sb[$];
  int  checks    = 0;
  int  failures  = 0;
  int  cyc       = 0;
  int  exp_count = 0;

  button_debouncer #(
    .DEBOUNCE_W  (20),
    .DEBOUNCE_MAX(DB),
    .LONG_W      (26),
    .LONG_MAX    (LONG),
    .ACTIVE_LOW  (1)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .btn_in       (btn_in),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse),
    .was_long     (was_long),
    .press_count  (press_count)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Press accepted 3+DB edges after the pin is driven (sync + debounce).
  task automatic push_press(input int n, output int p);
    ev_t e;
    p         = n + 3 + DB;
    exp_count = (exp_count + 1) % 256;
    e.kind     = EV_PRESS;
    e.cyc      = p;
    e.level    = 1'b1;
    e.was_long = 1'b0;
    e.count    = 8'(exp_count);
    sb.push_back(e);
  endtask

  // Release confirmed 3+DB edges after the pin is last driven released.
  task automatic push_release(input int p, input int m);
    ev_t e;
    int  r;
    r = m + 3 + DB;
    if (p + LONG < r) begin
      e.kind     = EV_LONG;
      e.cyc      = p + LONG;
      e.level    = 1'b1;
      e.was_long = 1'b0;
      e.count    = 8'(exp_count);
      sb.push_back(e);
    end
    e.kind     = EV_RELEASE;
    e.cyc      = r;
    e.level    = 1'b0;
    e.was_long = (r - p - 1 >= LONG);
    e.count    = 8'(exp_count);
    sb.push_back(e);
  endtask

  task automatic press_release(input int hold, input int idle);
    int p;
    push_press(cyc, p);
    push_release(p, cyc + hold);
    btn_in = 1'b0;
    repeat (hold) @(negedge sys_clk);
    btn_in = 1'b1;
    repeat (idle) @(negedge sys_clk);
  endtask

  task automatic drain(input string tag);
    check(tag, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  always @(negedge sys_clk) begin
    ev_t      e;
    ev_kind_t k;
    int       n;
    if (!sys_rst && (press_pulse || release_pulse || long_pulse)) begin
      n = int'(press_pulse) + int'(release_pulse) + int'(long_pulse);
      check("one_strobe_per_cycle", 32'(n), 32'd1);
      k = press_pulse ? EV_PRESS : (release_pulse ? EV_RELEASE : EV_LONG);
      if (sb.size() == 0) begin
        check("unexpected_event", 32'(k), 32'(EV_NONE));
      end else begin
        e = sb.pop_front();
        check("ev_kind",     32'(k),           32'(e.kind));
        check("ev_cycle",    32'(cyc),         32'(e.cyc));
        check("ev_level",    32'(btn_level),   32'(e.level));
        check("ev_was_long", 32'(was_long),    32'(e.was_long));
        check("ev_count",    32'(press_count), 32'(e.count));
      end
    end
  end

  initial begin
    int n, p;
    btn_in  = 1'b1;
    sys_rst = 1'b1;
    @(negedge sys_clk);
    check("reset_flags", 32'({btn_level, press_pulse, release_pulse, long_pulse, was_long}), 32'd0);
    check("reset_count", 32'(press_count), 32'd0);
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (3) @(negedge sys_clk);

    // Glitch shorter than the debounce window
    btn_in = 1'b0;
    repeat (3) @(negedge sys_clk);
    btn_in = 1'b1;
    repeat (10) @(negedge sys_clk);
    check("glitch_level", 32'(btn_level), 32'd0);
    check("glitch_count", 32'(press_count), 32'd0);
    drain("glitch_events");

    // Clean press, then bouncing release 1,0,1,0 then stable 1
    n = cyc;
    push_press(n, p);
    push_release(p, n + 14);
    btn_in = 1'b0;
    repeat (7) @(negedge sys_clk);
    check("press_level", 32'(btn_level), 32'd1);
    check("press_count_1", 32'(press_count), 32'd1);
    repeat (3) @(negedge sys_clk);
    btn_in = 1'b1; @(negedge sys_clk);
    check("bounce_level_a", 32'(btn_level), 32'd1);
    btn_in = 1'b0; @(negedge sys_clk);
    check("bounce_level_b", 32'(btn_level), 32'd1);
    btn_in = 1'b1; @(negedge sys_clk);
    check("bounce_level_c", 32'(btn_level), 32'd1);
    btn_in = 1'b0; @(negedge sys_clk);
    check("bounce_level_d", 32'(btn_level), 32'd1);
    btn_in = 1'b1;
    repeat (10) @(negedge sys_clk);
    check("bounce_released", 32'(btn_level), 32'd0);
    check("bounce_count", 32'(press_count), 32'd1);
    drain("bounce_events");

    // Hold lengths: long, short, release coinciding with threshold, one past it
    press_release(30, 10);
    drain("long_hold_events");
    press_release(5, 10);
    drain("short_hold_events");
    press_release(16, 10);
    drain("coincide_events");
    press_release(17, 10);
    drain("just_long_events");
    check("hold_tests_count", 32'(press_count), 32'd5);

    // Asynchronous reset mid-hold, button still held afterwards
    n = cyc;
    push_press(n, p);
    btn_in = 1'b0;
    repeat (12) @(negedge sys_clk);
    check("level_before_reset", 32'(btn_level), 32'd1);
    drain("pre_reset_events");
    #2 sys_rst = 1'b1;
    #1;
    check("async_reset_flags", 32'({btn_level, press_pulse, release_pulse, long_pulse, was_long}), 32'd0);
    check("async_reset_count", 32'(press_count), 32'd0);
    repeat (2) @(negedge sys_clk);
    sys_rst   = 1'b0;
    exp_count = 0;
    n = cyc;
    push_press(n, p);
    push_release(p, n + 10);
    repeat (10) @(negedge sys_clk);
    check("held_through_reset_count", 32'(press_count), 32'd1);
    btn_in = 1'b1;
    repeat (10) @(negedge sys_clk);
    drain("post_reset_events");

    // Counter wrap: 256 presses from zero return to 0, the next gives 1
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst   = 1'b0;
    exp_count = 0;
    repeat (2) @(negedge sys_clk);
    for (int i = 0; i < 256; i++) press_release(5, 9);
    check("wrap_to_zero", 32'(press_count), 32'd0);
    drain("wrap_events");
    press_release(5, 9);
    check("wrap_then_one", 32'(press_count), 32'd1);
    drain("final_events");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
